uart_rx_deserializer: RTL

//  Synthesizable 8-bit UART receiver. Deserializes the asynchronous serial line driven by the

---
 rtl/uart_rx_deserializer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8-bit UART receiver with 16x NCO oversampling and 1-entry holding register
module uart_rx_deserializer #(
  parameter int NcoWidth   = 16,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [NcoWidth-1:0] nco_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  input  logic                rx_i,
  output logic [7:0]          rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                parity_err_o,
  output logic                frame_err_o,
  output logic                overflow_o,
  output logic                break_o,
  output logic                idle_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                state_q, state_d;
  logic [SyncStages-1:0] sync_q;
  logic                  rx_s;
  logic [NcoWidth:0]     acc_q;
  logic                  tick;
  logic [3:0]            scnt_q, scnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  load_q, load_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;

  assign rx_s    = sync_q[SyncStages-1];
  assign tick    = acc_q[NcoWidth];
  assign break_o = (state_q == S_BREAK);
  assign idle_o  = (state_q == S_IDLE);

  // Bring the asynchronous line into the clock domain; idle-high so reset fills with ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SyncStages-2:0], rx_i};
  end

  // Baud NCO: the carry out of the accumulator is the 16x oversample tick.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) acc_q <= '0;
    else                    acc_q <= {1'b0, acc_q[NcoWidth-1:0]} + {1'b0, nco_i};
  end

  // Frame state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      scnt_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      load_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      load_q    <= load_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state logic: start qualification at half bit, then mid-bit sampling every 16 ticks.
  always_comb begin
    state_d   = state_q;
    scnt_d    = tick ? scnt_q + 4'd1 : scnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    load_d    = 1'b0;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          scnt_d  = '0;
        end
      end
      S_START: begin
        if (tick && scnt_q == 4'd7) begin
          scnt_d    = '0;
          bit_cnt_d = '0;
          par_d     = 1'b0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && scnt_q == 4'd15) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = parity_en_i ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick && scnt_q == 4'd15) begin
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && scnt_q == 4'd15) begin
          load_d = 1'b1;
          ferr_d = !rx_s;
          perr_d = parity_en_i & ((^{shreg_q, par_q}) ^ parity_odd_i);
          if (!rx_s && shreg_q == 8'h00 && (!parity_en_i || !par_q)) state_d = S_BREAK;
          else                                                       state_d = S_IDLE;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!enable_i) state_d = S_IDLE;
  end

  // Holding register: accept a completed byte if empty or being drained, else flag overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
      if (load_q) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o    <= shreg_q;
          rx_valid_o   <= 1'b1;
          parity_err_o <= perr_q;
          frame_err_o  <= ferr_q;
        end else begin
          overflow_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule
